// File: rtl/gyro_err_demod.sv
// gyro_err_demod: square-wave bias modulation driver with a synchronous
// demodulator. The block sums the ADC samples of each half-period separately
// and emits one scaled, polarity-corrected error per full modulation period.
module gyro_err_demod #(
  parameter int ADC_W = 14,
  parameter int CNT_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [CNT_W-1:0]        i_freq,
  input  logic [CNT_W-1:0]        i_wait_cnt,
  input  logic [4:0]              i_avg_sel,
  input  logic                    i_polarity,
  input  logic signed [ADC_W-1:0] i_adc,
  output logic                    o_mod,
  output logic signed [31:0]      o_err,
  output logic                    o_err_valid,
  output logic                    o_step_trig
);

  localparam int ACC_W  = ADC_W + CNT_W;
  localparam int DIFF_W = ACC_W + 1;

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        freq_l;
  logic [CNT_W-1:0]        wait_l;
  logic [4:0]              avg_l;
  logic                    pol_l;
  logic signed [ACC_W-1:0] sum_hi;
  logic signed [ACC_W-1:0] sum_lo;

  logic                     last_smp;
  logic                     take_smp;
  logic                     hi_entry;
  logic                     period_done;
  logic signed [ACC_W-1:0]  adc_ext;
  logic signed [ACC_W-1:0]  sum_lo_fin;
  logic signed [DIFF_W-1:0] hi_x;
  logic signed [DIFF_W-1:0] lo_x;
  logic signed [DIFF_W-1:0] diff_p0;

  // Sign-extend the difference to 32 bits, shift arithmetically (floor) and
  // optionally negate. The difference never reaches -2^31, so negation is safe.
  function automatic logic signed [31:0] scale_err(
    input logic signed [DIFF_W-1:0] d,
    input logic [4:0]               sh,
    input logic                     neg
  );
    logic signed [31:0] ext;
    logic signed [31:0] shd;
    ext = {{(32-DIFF_W){d[DIFF_W-1]}}, d};
    shd = ext >>> sh;
    return neg ? -shd : shd;
  endfunction

  // Clamp the requested half-period to the shortest usable length of 2.
  function automatic logic [CNT_W-1:0] clamp_freq(input logic [CNT_W-1:0] f);
    return (f < CNT_W'(2)) ? CNT_W'(2) : f;
  endfunction

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and per-clock control decodes.
  always_comb begin
    state_nxt   = state;
    hi_entry    = 1'b0;
    period_done = 1'b0;
    last_smp    = (cnt == freq_l - CNT_W'(1));
    take_smp    = (cnt >= wait_l);
    case (state)
      IDLE: begin
        if (i_en) begin
          state_nxt = HI;
          hi_entry  = 1'b1;
        end
      end
      HI: begin
        if (!i_en)         state_nxt = IDLE;
        else if (last_smp) state_nxt = LO;
      end
      LO: begin
        if (!i_en) begin
          state_nxt = IDLE;
        end else if (last_smp) begin
          state_nxt   = HI;
          hi_entry    = 1'b1;
          period_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: the final LO sample is folded in combinationally so the error
  // can register on the same edge that starts the next period.
  always_comb begin
    adc_ext    = {{CNT_W{i_adc[ADC_W-1]}}, i_adc};
    sum_lo_fin = take_smp ? (sum_lo + adc_ext) : sum_lo;
    hi_x       = {sum_hi[ACC_W-1], sum_hi};
    lo_x       = {sum_lo_fin[ACC_W-1], sum_lo_fin};
    diff_p0    = hi_x - lo_x;
  end

  // Counter, config latch, accumulators and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt         <= '0;
      freq_l      <= CNT_W'(2);
      wait_l      <= '0;
      avg_l       <= '0;
      pol_l       <= 1'b0;
      sum_hi      <= '0;
      sum_lo      <= '0;
      o_mod       <= 1'b0;
      o_err       <= '0;
      o_err_valid <= 1'b0;
      o_step_trig <= 1'b0;
    end else begin
      o_err_valid <= 1'b0;
      o_step_trig <= 1'b0;
      o_mod       <= (state_nxt == HI);

      if (hi_entry || state_nxt == IDLE || last_smp) cnt <= '0;
      else                                           cnt <= cnt + CNT_W'(1);

      if (hi_entry || state_nxt == IDLE) begin
        sum_hi <= '0;
        sum_lo <= '0;
      end else if (state == HI && take_smp) begin
        sum_hi <= sum_hi + adc_ext;
      end else if (state == LO && take_smp) begin
        sum_lo <= sum_lo + adc_ext;
      end

      if (hi_entry) begin
        freq_l      <= clamp_freq(i_freq);
        wait_l      <= i_wait_cnt;
        avg_l       <= i_avg_sel;
        pol_l       <= i_polarity;
        o_step_trig <= 1'b1;
      end

      // Stage p1: registered error, using the config of the period just ended.
      if (period_done) begin
        o_err       <= scale_err(diff_p0, avg_l, pol_l);
        o_err_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gyro_err_demod.sv
// Testbench for gyro_err_demod: randomized and directed stimulus compared
// cycle by cycle against a sample-list reference model of the demodulator.
module tb_gyro_err_demod;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [15:0]        freq;
  logic [15:0]        wait_cnt;
  logic [4:0]         avg_sel;
  logic               polarity;
  logic signed [13:0] adc;
  logic               mod_o;
  logic signed [31:0] err_o;
  logic               err_valid;
  logic               step_trig;

  gyro_err_demod #(.ADC_W(14), .CNT_W(16)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .i_freq      (freq),
    .i_wait_cnt  (wait_cnt),
    .i_avg_sel   (avg_sel),
    .i_polarity  (polarity),
    .i_adc       (adc),
    .o_mod       (mod_o),
    .o_err       (err_o),
    .o_err_valid (err_valid),
    .o_step_trig (step_trig)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a period is the list of its 2*f samples.
  bit          run;
  int          f_m, w_m, a_m;
  bit          p_m;
  longint      samples[$];
  longint      exp_err;
  bit          exp_valid, exp_trig, exp_mod;

  int          adc_mode;   // 0 const, 1 +-30 by half, 2 random, 3 extremes
  int          adc_const;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint period_err();
    longint hi = 0;
    longint lo = 0;
    longint d;
    for (int i = w_m; i < f_m; i++) begin
      hi += samples[i];
      lo += samples[f_m + i];
    end
    d = (hi - lo) >>> a_m;
    if (p_m) d = -d;
    return d;
  endfunction

  task automatic model_step();
    if (rst) begin
      run = 0; samples.delete();
      exp_err = 0; exp_valid = 0; exp_trig = 0; exp_mod = 0;
      return;
    end
    exp_valid = 0;
    exp_trig  = 0;
    if (!en) begin
      run = 0;
      samples.delete();
      exp_mod = 0;
      return;
    end
    if (run) begin
      samples.push_back(longint'(adc));
      if (samples.size() == 2 * f_m) begin
        exp_err   = period_err();
        exp_valid = 1;
        run       = 0;
      end else begin
        exp_mod = (samples.size() < f_m);
      end
    end
    if (!run) begin
      run = 1;
      samples.delete();
      f_m = (freq < 2) ? 2 : int'(freq);
      w_m = int'(wait_cnt);
      a_m = int'(avg_sel);
      p_m = polarity;
      exp_trig = 1;
      exp_mod  = 1;
    end
  endtask

  task automatic cyc();
    case (adc_mode)
      0:       adc = 14'(adc_const);
      1:       adc = exp_mod ? 14'sd30 : -14'sd30;
      2:       adc = 14'($urandom_range(0, 16383));
      default: adc = exp_mod ? -14'sd8192 : 14'sd8191;
    endcase
    @(posedge clk);
    model_step();
    #1;
    chk("mod", longint'(mod_o), longint'(exp_mod));
    chk("valid", longint'(err_valid), longint'(exp_valid));
    chk("trig", longint'(step_trig), longint'(exp_trig));
    chk("err", longint'(err_o), exp_err);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic restart(input int fq, input int wt, input int av, input bit pl, input int md);
    en = 0; cyc();
    freq = 16'(fq); wait_cnt = 16'(wt); avg_sel = 5'(av); polarity = pl; adc_mode = md;
    en = 1;
  endtask

  initial begin
    rst = 1; en = 0; freq = 16'd8; wait_cnt = 16'd2; avg_sel = 0; polarity = 0;
    adc = 0; adc_mode = 0; adc_const = 100;
    run = 0; exp_err = 0; exp_valid = 0; exp_trig = 0; exp_mod = 0;
    cycles(2);
    chk("rst_err", longint'(err_o), 0);
    chk("rst_mod", longint'(mod_o), 0);
    rst = 0;

    // Constant input cancels.
    restart(8, 2, 0, 0, 0);
    cycles(50);
    chk("const_err", longint'(err_o), 0);

    // Square-wave input in phase with the modulation.
    restart(8, 2, 0, 0, 1); cycles(33);
    chk("sq_err", longint'(err_o), 360);
    restart(8, 2, 2, 0, 1); cycles(33);
    chk("sq_avg2", longint'(err_o), 90);
    restart(8, 2, 0, 1, 1); cycles(33);
    chk("sq_pol", longint'(err_o), -360);

    // Settling window covers the whole half.
    restart(8, 8, 0, 0, 2); cycles(40);
    chk("wait_all", longint'(err_o), 0);

    // Drop enable at cnt=3 of HI, then re-enable.
    restart(8, 2, 0, 0, 1); cycles(16 + 4);
    en = 0; cyc();
    chk("drop_mod", longint'(mod_o), 0);
    cycles(3);
    en = 1; cycles(20);

    // Half-period change in the middle of LO.
    restart(8, 1, 0, 0, 2); cycles(12);
    freq = 16'd4; cycles(40);

    // Reset for one clock in the middle of HI with enable held.
    restart(6, 1, 0, 0, 1); cycles(15);
    rst = 1; cyc();
    chk("rst_mid_trig", longint'(step_trig), 0);
    chk("rst_mid_err", longint'(err_o), 0);
    rst = 0; cycles(30);

    // Randomized configurations, occasional enable drops.
    for (int k = 0; k < 14; k++) begin
      restart($urandom_range(0, 12), $urandom_range(0, 10), $urandom_range(0, 31),
              1'($urandom_range(0, 1)), (k % 3 == 0) ? 3 : 2);
      for (int c = 0; c < 80; c++) begin
        en = ($urandom_range(0, 39) != 0);
        if ($urandom_range(0, 19) == 0) freq = 16'($urandom_range(0, 12));
        cyc();
      end
    end

    // Long period with extreme samples: large sums, negative result.
    restart(12000, 0, 0, 0, 3);
    cycles(24001);
    chk("big_err", longint'(err_o), -longint'(12000) * (8192 + 8191));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
